// File: rtl/fighter_core.sv
// fighter_core: one fighter's move/attack/stun state machine with position tracking.
// State, frame timer and position advance only on ticks where the round is running;
// a round-start pulse or rst returns the fighter to its spawn point.
// Optional feature macro: FIGHTER_KNOCKBACK_EN -- pushes the fighter 1 pixel away
// from the opponent on every running tick spent in HITSTUN.
module fighter_core #(
  parameter int SIDE     = 0,
  parameter int POS_W    = 10,
  parameter int TMR_W    = 6,
  parameter int X_MIN    = 10,
  parameter int X_MAX    = 517,
  parameter int SPAWN_X  = 100,
  parameter int MIN_GAP  = 30,
  parameter int SPD_FWD  = 3,
  parameter int SPD_BACK = 2,
  parameter int B_START  = 5,
  parameter int B_ACT    = 2,
  parameter int B_REC    = 16,
  parameter int D_START  = 4,
  parameter int D_ACT    = 3,
  parameter int D_REC    = 15,
  parameter int HIT_B    = 16,
  parameter int HIT_D    = 16,
  parameter int BLK_B    = 14,
  parameter int BLK_D    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             run_i,
  input  logic             start_i,
  input  logic             left_i,
  input  logic             right_i,
  input  logic             attack_i,
  input  logic [POS_W-1:0] opp_x_i,
  input  logic [1:0]       hit_i,
  input  logic             ko_i,
  output logic [POS_W-1:0] posx_o,
  output logic [3:0]       state_o,
  output logic             hit_active_o,
  output logic             hit_dir_o,
  output logic             blocking_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FWD       = 4'd1,
    S_BACK      = 4'd2,
    S_B_START   = 4'd3,
    S_B_ACT     = 4'd4,
    S_B_REC     = 4'd5,
    S_D_START   = 4'd6,
    S_D_ACT     = 4'd7,
    S_D_REC     = 4'd8,
    S_HITSTUN   = 4'd9,
    S_BLOCKSTUN = 4'd10,
    S_KO        = 4'd11
  } state_e;

  // Two extra bits give headroom for sign and overflow so clamps never see a wrap.
  localparam int PW = POS_W + 2;
  typedef logic signed [PW-1:0] spos_t;

  localparam spos_t X_MIN_S   = spos_t'(X_MIN);
  localparam spos_t X_MAX_S   = spos_t'(X_MAX);
  localparam spos_t GAP_S     = spos_t'(MIN_GAP);
  localparam spos_t SPD_F_S   = spos_t'(SPD_FWD);
  localparam spos_t SPD_B_S   = spos_t'(SPD_BACK);
  localparam spos_t ZERO_S    = spos_t'(0);
  localparam logic [POS_W-1:0] RESET_X = (SIDE == 0) ? POS_W'(SPAWN_X)
                                                     : POS_W'(X_MAX + X_MIN - SPAWN_X);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONES = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  // Timer value on the final tick of a fixed-length phase; length 0 behaves as 1.
  function automatic logic [TMR_W-1:0] last_tick_p(input int len);
    logic [TMR_W-1:0] r;
    if (len <= 1) r = TMR_ZERO;
    else          r = TMR_W'(len - 1);
    return r;
  endfunction

  // Timer value on the final tick of a latched stun length; length 0 behaves as 1.
  function automatic logic [TMR_W-1:0] last_tick_v(input logic [TMR_W-1:0] len);
    logic [TMR_W-1:0] r;
    if (len == TMR_ZERO) r = TMR_ZERO;
    else                 r = len - TMR_ONE;
    return r;
  endfunction

  // Stun length selected by hit kind and whether the hit was blocked.
  function automatic logic [TMR_W-1:0] stun_len(input logic blocked, input logic [1:0] kind);
    logic [TMR_W-1:0] r;
    if (blocked) r = (kind == 2'b10) ? TMR_W'(BLK_D) : TMR_W'(BLK_B);
    else         r = (kind == 2'b10) ? TMR_W'(HIT_D) : TMR_W'(HIT_B);
    return r;
  endfunction

  // Keep a position inside the arena bounds.
  function automatic spos_t clamp_x(input spos_t v);
    spos_t r;
    if (v < X_MIN_S)      r = X_MIN_S;
    else if (v > X_MAX_S) r = X_MAX_S;
    else                  r = v;
    return r;
  endfunction

  state_e            state_q, state_d, dir_state_s;
  logic [TMR_W-1:0]  timer_q, timer_d, stun_q, stun_d;
  logic [POS_W-1:0]  posx_q, posx_d;
  logic              hit_active_q, hit_dir_q, blocking_q;
  logic              qual_s, hit_valid_s, hit_vuln_s, expire_s, away_dn_s;
  spos_t             px_s, opp_s, diff_s, gap_s, cand_s;

  assign qual_s       = tick_i & run_i;
  assign posx_o       = posx_q;
  assign state_o      = state_q;
  assign hit_active_o = hit_active_q;
  assign hit_dir_o    = hit_dir_q;
  assign blocking_o   = blocking_q;

  // Direction decode: both held means back off; otherwise mirrored by SIDE.
  always_comb begin
    dir_state_s = S_IDLE;
    if (left_i && right_i) begin
      dir_state_s = S_BACK;
    end else if (right_i) begin
      dir_state_s = (SIDE == 0) ? S_FWD : S_BACK;
    end else if (left_i) begin
      dir_state_s = (SIDE == 0) ? S_BACK : S_FWD;
    end else begin
      dir_state_s = S_IDLE;
    end
  end

  // Next-state and stun-latch selection in priority order ko > hit > expiry > attack > direction.
  always_comb begin
    state_d     = state_q;
    stun_d      = stun_q;
    hit_valid_s = (hit_i == 2'b01) || (hit_i == 2'b10);
    hit_vuln_s  = 1'b0;
    expire_s    = 1'b0;
    case (state_q)
      S_IDLE, S_FWD:          hit_vuln_s = 1'b1;
      S_B_START, S_B_ACT, S_B_REC,
      S_D_START, S_D_ACT, S_D_REC: hit_vuln_s = 1'b1;
      default:                hit_vuln_s = 1'b0;
    endcase
    case (state_q)
      S_B_START:              expire_s = (timer_q == last_tick_p(B_START));
      S_B_ACT:                expire_s = (timer_q == last_tick_p(B_ACT));
      S_B_REC:                expire_s = (timer_q == last_tick_p(B_REC));
      S_D_START:              expire_s = (timer_q == last_tick_p(D_START));
      S_D_ACT:                expire_s = (timer_q == last_tick_p(D_ACT));
      S_D_REC:                expire_s = (timer_q == last_tick_p(D_REC));
      S_HITSTUN, S_BLOCKSTUN: expire_s = (timer_q == last_tick_v(stun_q));
      default:                expire_s = 1'b0;
    endcase
    if (state_q == S_KO) begin
      state_d = S_KO;
    end else if (ko_i) begin
      state_d = S_KO;
    end else if (hit_valid_s && (state_q == S_BACK)) begin
      state_d = S_BLOCKSTUN;
      stun_d  = stun_len(1'b1, hit_i);
    end else if (hit_valid_s && hit_vuln_s) begin
      state_d = S_HITSTUN;
      stun_d  = stun_len(1'b0, hit_i);
    end else begin
      case (state_q)
        S_IDLE:         state_d = attack_i ? S_B_START : dir_state_s;
        S_FWD, S_BACK:  state_d = attack_i ? S_D_START : dir_state_s;
        S_B_START:      state_d = expire_s ? S_B_ACT : S_B_START;
        S_B_ACT:        state_d = expire_s ? S_B_REC : S_B_ACT;
        S_D_START:      state_d = expire_s ? S_D_ACT : S_D_START;
        S_D_ACT:        state_d = expire_s ? S_D_REC : S_D_ACT;
        S_B_REC, S_D_REC, S_HITSTUN, S_BLOCKSTUN:
                        state_d = expire_s ? (attack_i ? S_B_START : dir_state_s) : state_q;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Frame timer: restart on any state change, otherwise count up and saturate.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = TMR_ZERO;
    end else if (timer_q == TMR_ONES) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
  end

  // Position update: approach with gap clamp in FWD, retreat in BACK, optional knockback in HITSTUN.
  always_comb begin
    px_s      = $signed({2'b00, posx_q});
    opp_s     = $signed({2'b00, opp_x_i});
    diff_s    = px_s - opp_s;
    gap_s     = (diff_s < ZERO_S) ? -diff_s : diff_s;
    away_dn_s = (opp_s > px_s) || ((opp_s == px_s) && (SIDE == 0));
    cand_s    = px_s;
    if (!ko_i) begin
      case (state_q)
        S_FWD: begin
          if (!hit_valid_s && (gap_s >= GAP_S)) begin
            if (opp_s > px_s) begin
              cand_s = px_s + SPD_F_S;
              if (cand_s > opp_s - GAP_S) cand_s = opp_s - GAP_S;
              else                        cand_s = cand_s;
            end else begin
              cand_s = px_s - SPD_F_S;
              if (cand_s < opp_s + GAP_S) cand_s = opp_s + GAP_S;
              else                        cand_s = cand_s;
            end
            cand_s = clamp_x(cand_s);
          end else begin
            cand_s = px_s;
          end
        end
        S_BACK: begin
          if (!hit_valid_s) cand_s = clamp_x(away_dn_s ? px_s - SPD_B_S : px_s + SPD_B_S);
          else              cand_s = px_s;
        end
`ifdef FIGHTER_KNOCKBACK_EN
        S_HITSTUN: cand_s = clamp_x(away_dn_s ? px_s - spos_t'(1) : px_s + spos_t'(1));
`else
        S_HITSTUN: cand_s = px_s;
`endif
        default:   cand_s = px_s;
      endcase
    end else begin
      cand_s = px_s;
    end
    posx_d = cand_s[POS_W-1:0];
  end

  // State, timer, stun, position and output-flag registers; start acts like a reset.
  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      state_q      <= S_IDLE;
      timer_q      <= TMR_ZERO;
      stun_q       <= TMR_ZERO;
      posx_q       <= RESET_X;
      hit_active_q <= 1'b0;
      hit_dir_q    <= 1'b0;
      blocking_q   <= 1'b0;
    end else if (qual_s) begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stun_q       <= stun_d;
      posx_q       <= posx_d;
      hit_active_q <= (state_d == S_B_ACT) || (state_d == S_D_ACT);
      hit_dir_q    <= (state_d == S_D_ACT);
      blocking_q   <= (state_d == S_BACK) || (state_d == S_BLOCKSTUN);
    end
  end

endmodule
